// File: rtl/beam_delay_ctrl_if.sv
// beam_delay_ctrl_if
//   Serial configuration handshake for the beam delay controller.
//   cfg_valid : a config bit is present this cycle (driven by the master)
//   cfg_bit   : serial config data, MSB first   (driven by the master)
//   cfg_ready : the controller accepts a bit this cycle (driven by the slave)
interface beam_delay_ctrl_if;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (output cfg_valid, output cfg_bit, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_bit, output cfg_ready);
endinterface

// File: rtl/beam_delay_ctrl.sv
// beam_delay_ctrl
//   Receives serial config frames {channel[2:0], delay[IDX_W-1:0], parity},
//   stages accepted delays per channel in shadow registers and applies all
//   staged channels together on the next audio frame boundary.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   cfg           : serial config handshake (slave side)
//   frame_strobe  : one-cycle frame boundary pulse
//   delay_flat    : active read index per channel, channel c at [c*IDX_W +: IDX_W]
//   pending       : per-channel staged-but-uncommitted flags
//   commit_pulse  : one cycle after a strobe that applied staged values
//   err_pulse     : one cycle after a frame was rejected
//   err_code      : last error cause (1 parity, 2 channel range, 3 timeout)
//   err_count     : rejected frames, saturating at 255
module beam_delay_ctrl #(
  parameter int NUM_CHANNELS = 8,
  parameter int BUFFER_SIZE  = 16,
  parameter int TIMEOUT      = 64,
  localparam int IDX_W       = $clog2(BUFFER_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  beam_delay_ctrl_if.slave              cfg,
  input  logic                          frame_strobe,
  output logic [NUM_CHANNELS*IDX_W-1:0] delay_flat,
  output logic [NUM_CHANNELS-1:0]       pending,
  output logic                          commit_pulse,
  output logic                          err_pulse,
  output logic [1:0]                    err_code,
  output logic [7:0]                    err_count
);

  localparam int FRAME_LEN = 4 + IDX_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int GAP_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // The parity bit makes the whole frame (parity included) carry an even number of ones.
  function automatic logic parity_ok(input logic [FRAME_LEN-1:0] frame);
    return ~(^frame);
  endfunction

  state_t                   state_r, state_nxt_s;
  logic                     ready_r;
  logic                     xfer_s, timeout_s, check_s;
  logic [FRAME_LEN-1:0]     frame_r;
  logic [CNT_W-1:0]         bit_cnt_r;
  logic [GAP_W-1:0]         gap_cnt_r;
  logic [2:0]               ch_s;
  logic [IDX_W-1:0]         dly_s;
  logic                     par_ok_s, ch_ok_s, accept_s, err_s;
  logic [1:0]               code_s;
  logic [NUM_CHANNELS-1:0]  accept_mask_s;
  logic                     commit_s;
  logic [IDX_W-1:0]         shadow_r [NUM_CHANNELS];
  logic [NUM_CHANNELS*IDX_W-1:0] delay_r;
  logic [NUM_CHANNELS-1:0]  pending_r;
  logic                     commit_pulse_r, err_pulse_r;
  logic [1:0]               err_code_r;
  logic [7:0]               err_count_r;

  assign xfer_s        = cfg.cfg_valid & ready_r;
  assign cfg.cfg_ready = ready_r;

  assign ch_s     = frame_r[FRAME_LEN-1 -: 3];
  assign dly_s    = frame_r[IDX_W:1];
  assign par_ok_s = parity_ok(frame_r);
  assign ch_ok_s  = ({29'd0, ch_s} < 32'(NUM_CHANNELS));
  // The pending set seen here is the pre-CHECK one, so a frame accepted on
  // the strobe cycle waits for the following strobe.
  assign commit_s = frame_strobe & (pending_r != {NUM_CHANNELS{1'b0}});

  // State register; ready is registered from the next state so it is low exactly during CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != CHECK);
    end
  end

  // Next-state logic and frame-level control strobes.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    check_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_nxt_s = SHIFT;
        else        state_nxt_s = IDLE;
      end
      SHIFT: begin
        // cfg_ready is high in SHIFT, so no transfer means cfg_valid is low.
        if (xfer_s) begin
          if (bit_cnt_r == CNT_W'(FRAME_LEN - 1)) state_nxt_s = CHECK;
          else                                     state_nxt_s = SHIFT;
        end else if (gap_cnt_r == GAP_W'(TIMEOUT - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      CHECK: begin
        check_s     = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame verdict: parity beats channel range; timeouts never coincide with CHECK.
  always_comb begin
    accept_s = 1'b0;
    err_s    = 1'b0;
    code_s   = 2'd0;
    if (timeout_s) begin
      err_s  = 1'b1;
      code_s = 2'd3;
    end else if (check_s) begin
      if (!par_ok_s) begin
        err_s  = 1'b1;
        code_s = 2'd1;
      end else if (!ch_ok_s) begin
        err_s  = 1'b1;
        code_s = 2'd2;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // One-hot of the channel being staged this cycle.
  always_comb begin
    accept_mask_s = {NUM_CHANNELS{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept_s && (ch_s == 3'(c))) accept_mask_s[c] = 1'b1;
      else                             accept_mask_s[c] = 1'b0;
    end
  end

  // Serial shifter, bit counter and inter-bit gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_r   <= {FRAME_LEN{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      if (xfer_s) begin
        frame_r   <= {frame_r[FRAME_LEN-2:0], cfg.cfg_bit};
        bit_cnt_r <= (state_r == IDLE) ? CNT_W'(1) : bit_cnt_r + CNT_W'(1);
        gap_cnt_r <= {GAP_W{1'b0}};
      end else if (state_r == SHIFT) begin
        gap_cnt_r <= timeout_s ? {GAP_W{1'b0}} : gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  // Shadow staging, pending flags and atomic commit into the active indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_r        <= {(NUM_CHANNELS*IDX_W){1'b0}};
      pending_r      <= {NUM_CHANNELS{1'b0}};
      commit_pulse_r <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) shadow_r[c] <= {IDX_W{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (commit_s && pending_r[c]) delay_r[c*IDX_W +: IDX_W] <= shadow_r[c];
        if (accept_mask_s[c])         shadow_r[c] <= dly_s;
      end
      pending_r      <= (commit_s ? {NUM_CHANNELS{1'b0}} : pending_r) | accept_mask_s;
      commit_pulse_r <= commit_s;
    end
  end

  // Error reporting; accepted frames leave err_code alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse_r <= 1'b0;
      err_code_r  <= 2'd0;
      err_count_r <= 8'd0;
    end else begin
      err_pulse_r <= err_s;
      if (err_s) err_code_r <= code_s;
      if (err_s && (err_count_r != 8'hFF)) err_count_r <= err_count_r + 8'd1;
    end
  end

  assign delay_flat   = delay_r;
  assign pending      = pending_r;
  assign commit_pulse = commit_pulse_r;
  assign err_pulse    = err_pulse_r;
  assign err_code     = err_code_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_beam_delay_ctrl.sv
// tb_beam_delay_ctrl
//   Directed frames into an 8-channel and a 6-channel controller. Stimulus
//   pushes the expected error, commit and pending-change events into queues;
//   monitors pop and compare whenever the DUT shows such an event.
//   Frames are written {channel, delay, parity} with the parity bit making
//   the total number of ones even.
module tb_beam_delay_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_strobe = 1'b0;

  logic [31:0] flat8;
  logic [7:0]  pend8, cnt8;
  logic        cp8, ep8;
  logic [1:0]  ec8;
  logic [23:0] flat6;
  logic [5:0]  pend6;
  logic [7:0]  cnt6;
  logic        cp6, ep6;
  logic [1:0]  ec6;

  beam_delay_ctrl_if bus8();
  beam_delay_ctrl_if bus6();

  beam_delay_ctrl #(.NUM_CHANNELS(8), .BUFFER_SIZE(16), .TIMEOUT(64)) dut8 (
    .clk(clk), .reset(reset), .cfg(bus8.slave), .frame_strobe(frame_strobe),
    .delay_flat(flat8), .pending(pend8), .commit_pulse(cp8),
    .err_pulse(ep8), .err_code(ec8), .err_count(cnt8));

  beam_delay_ctrl #(.NUM_CHANNELS(6), .BUFFER_SIZE(16), .TIMEOUT(64)) dut6 (
    .clk(clk), .reset(reset), .cfg(bus6.slave), .frame_strobe(frame_strobe),
    .delay_flat(flat6), .pending(pend6), .commit_pulse(cp6),
    .err_pulse(ep6), .err_code(ec6), .err_count(cnt6));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] code; logic [7:0] cnt; int cyc; } err_t;
  typedef struct { logic [31:0] flat; logic [7:0] pend; } com_t;

  err_t       err8_q[$];
  err_t       err6_q[$];
  com_t       com8_q[$];
  logic [7:0] pend8_q[$];
  logic [5:0] pend6_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitor for the 8-channel build.
  logic [7:0] prev8 = 8'h00;
  always @(negedge clk) begin
    err_t e;
    com_t m;
    logic [7:0] p;
    if (mon_en) begin
      if (ep8) begin
        if (err8_q.size() == 0) unexpected("err_pulse8");
        else begin
          e = err8_q.pop_front();
          chk("err_code8", 64'(ec8), 64'(e.code));
          chk("err_count8", 64'(cnt8), 64'(e.cnt));
          if (e.cyc >= 0) chk("timeout_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (cp8) begin
        if (com8_q.size() == 0) unexpected("commit_pulse8");
        else begin
          m = com8_q.pop_front();
          chk("commit_flat8", 64'(flat8), 64'(m.flat));
          chk("commit_pend8", 64'(pend8), 64'(m.pend));
        end
      end
      if (pend8 !== prev8) begin
        if (pend8_q.size() == 0) unexpected("pending8_change");
        else begin
          p = pend8_q.pop_front();
          chk("pending8", 64'(pend8), 64'(p));
        end
      end
    end
    prev8 = pend8;
  end

  // Monitor for the 6-channel build.
  logic [5:0] prev6 = 6'h00;
  always @(negedge clk) begin
    err_t e;
    logic [5:0] p;
    if (mon_en) begin
      if (ep6) begin
        if (err6_q.size() == 0) unexpected("err_pulse6");
        else begin
          e = err6_q.pop_front();
          chk("err_code6", 64'(ec6), 64'(e.code));
          chk("err_count6", 64'(cnt6), 64'(e.cnt));
        end
      end
      if (cp6) unexpected("commit_pulse6");
      if (pend6 !== prev6) begin
        if (pend6_q.size() == 0) unexpected("pending6_change");
        else begin
          p = pend6_q.pop_front();
          chk("pending6", 64'(pend6), 64'(p));
        end
      end
    end
    prev6 = pend6;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the top n bits of f, MSB first, waiting out any not-ready cycle.
  task automatic send_bits(input int which, input logic [7:0] f, input int n);
    int   tries;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      tries = 0;
      do begin
        if (which == 0) begin
          bus8.cfg_valid = 1'b1;
          bus8.cfg_bit   = f[7-i];
          rdy            = bus8.cfg_ready;
        end else begin
          bus6.cfg_valid = 1'b1;
          bus6.cfg_bit   = f[7-i];
          rdy            = bus6.cfg_ready;
        end
        tick(1);
        tries++;
      end while (!rdy && tries < 8);
      if (!rdy) unexpected("cfg_ready_stuck_low");
    end
    bus8.cfg_valid = 1'b0;
    bus6.cfg_valid = 1'b0;
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    tick(1);
    frame_strobe = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_flat"},      64'(flat8), 64'h0);
    chk({tag, "_pending"},   64'(pend8), 64'h0);
    chk({tag, "_commit"},    64'(cp8),   64'h0);
    chk({tag, "_err_pulse"}, 64'(ep8),   64'h0);
    chk({tag, "_err_code"},  64'(ec8),   64'h0);
    chk({tag, "_err_count"}, 64'(cnt8),  64'h0);
    chk({tag, "_cfg_ready"}, 64'(bus8.cfg_ready), 64'h1);
  endtask

  int   exp_cnt;
  int   budget;

  initial begin
    bus8.cfg_valid = 1'b0; bus8.cfg_bit = 1'b0;
    bus6.cfg_valid = 1'b0; bus6.cfg_bit = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    mon_en = 1'b1;
    tick(1);

    // ch2 <- 5, then commit: only ch2's nibble moves.
    pend8_q.push_back(8'h04);
    send_bits(0, 8'b010_0101_1, 8);
    tick(3);
    com8_q.push_back('{32'h0000_0500, 8'h00});
    pend8_q.push_back(8'h00);
    strobe();
    tick(3);

    // Bad parity: error, pending untouched.
    err8_q.push_back('{2'd1, 8'd1, -1});
    send_bits(0, 8'b001_0011_0, 8);
    tick(3);

    // Three bits then silence: timeout lands exactly 64 idle cycles later.
    send_bits(0, 8'b101_00000, 3);
    err8_q.push_back('{2'd3, 8'd2, cyc + 64});
    tick(64);
    pend8_q.push_back(8'h08);
    send_bits(0, 8'b011_1010_0, 8);
    tick(3);
    com8_q.push_back('{32'h0000_A500, 8'h00});
    pend8_q.push_back(8'h00);
    strobe();
    tick(3);

    // ch1 pending; ch2's CHECK coincides with the strobe.
    pend8_q.push_back(8'h02);
    send_bits(0, 8'b001_0111_0, 8);
    tick(2);
    pend8_q.push_back(8'h04);
    com8_q.push_back('{32'h0000_A570, 8'h04});
    send_bits(0, 8'b010_1100_1, 8);
    strobe();
    tick(3);
    com8_q.push_back('{32'h0000_AC70, 8'h00});
    pend8_q.push_back(8'h00);
    strobe();
    tick(3);

    // Idle strobe with nothing pending does nothing.
    strobe();
    tick(2);

    // ch0 written 3 then 12: last write wins.
    pend8_q.push_back(8'h01);
    send_bits(0, 8'b000_0011_0, 8);
    send_bits(0, 8'b000_1100_0, 8);
    tick(3);
    com8_q.push_back('{32'h0000_AC7C, 8'h00});
    pend8_q.push_back(8'h00);
    strobe();
    tick(3);

    // Error counter saturates at 255.
    exp_cnt = 2;
    for (int k = 0; k < 256; k++) begin
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      err8_q.push_back('{2'd1, 8'(exp_cnt), -1});
      send_bits(0, 8'b001_0011_0, 8);
    end
    tick(3);

    // Reset mid-frame, coincident with a strobe, with ch5 pending: no commit.
    pend8_q.push_back(8'h20);
    send_bits(0, 8'b101_0110_0, 8);
    tick(3);
    send_bits(0, 8'b110_00000, 3);
    pend8_q.push_back(8'h00);
    reset = 1'b1;
    frame_strobe = 1'b1;
    tick(1);
    frame_strobe = 1'b0;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("midframe_reset");
    tick(1);

    // Recovery: a fresh frame is staged and committed normally.
    pend8_q.push_back(8'h02);
    send_bits(0, 8'b001_0111_0, 8);
    tick(3);
    com8_q.push_back('{32'h0000_0070, 8'h00});
    pend8_q.push_back(8'h00);
    strobe();
    tick(3);

    // 6-channel build: channels 7 and 6 out of range, channel 5 accepted.
    err6_q.push_back('{2'd2, 8'd1, -1});
    send_bits(1, 8'b111_1001_1, 8);
    tick(3);
    err6_q.push_back('{2'd2, 8'd2, -1});
    send_bits(1, 8'b110_0001_1, 8);
    tick(3);
    pend6_q.push_back(6'h20);
    send_bits(1, 8'b101_0010_1, 8);
    tick(3);

    budget = 0;
    while ((err8_q.size() + err6_q.size() + com8_q.size() + pend8_q.size() + pend6_q.size()) != 0
           && budget < 50) begin
      tick(1);
      budget++;
    end
    chk("sb_err8_left",  64'(err8_q.size()),  64'h0);
    chk("sb_err6_left",  64'(err6_q.size()),  64'h0);
    chk("sb_com8_left",  64'(com8_q.size()),  64'h0);
    chk("sb_pend8_left", 64'(pend8_q.size()), 64'h0);
    chk("sb_pend6_left", 64'(pend6_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
